// File: rtl/datapath_ctrl.sv
// Control sequencer for a small RA/RB/RZ datapath: accepts one operation at a time
// and walks the register load/drive enables through T0/T1/T2/TMOV, then pulses done.
module datapath_ctrl (
  input  logic        clk,
  input  logic        clear,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] imm,
  output logic        RAin,
  output logic        RBin,
  output logic        RZin,
  output logic        RAout,
  output logic        RBout,
  output logic        RZout,
  output logic [31:0] RegisterAImmediate,
  output logic [31:0] AddImmediate,
  output logic        busy,
  output logic        done,
  output logic [7:0]  op_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    TMOV = 3'd4,
    DONE = 3'd5
  } state_e;

  localparam logic [1:0] OP_LDA   = 2'b00;
  localparam logic [1:0] OP_ADDI  = 2'b01;
  localparam logic [1:0] OP_LDADD = 2'b10;
  localparam logic [1:0] OP_MOVBA = 2'b11;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] imm_q, imm_d;
  logic [7:0]  op_count_q, op_count_d;

  // State, captured operation and completion counter
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q    <= IDLE;
      op_q       <= 2'b00;
      imm_q      <= 32'd0;
      op_count_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      imm_q      <= imm_d;
      op_count_q <= op_count_d;
    end
  end

  // Next-state: op/imm only sampled in IDLE, so requests while busy are dropped
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    imm_d      = imm_q;
    op_count_d = op_count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op;
          imm_d = imm;
          case (op)
            OP_LDA:   state_d = T0;
            OP_ADDI:  state_d = T1;
            OP_LDADD: state_d = T0;
            OP_MOVBA: state_d = TMOV;
            default:  state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      T0: begin
        if (op_q == OP_LDADD) begin
          state_d = T1;
        end else begin
          state_d = DONE;
        end
      end
      T1:   state_d = T2;
      T2:   state_d = DONE;
      TMOV: state_d = DONE;
      DONE: begin
        state_d    = IDLE;
        op_count_d = op_count_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode purely from state_q/imm_q so every enable is glitch-free for its whole state
  always_comb begin
    RAin               = 1'b0;
    RBin               = 1'b0;
    RZin               = 1'b0;
    RAout              = 1'b0;
    RBout              = 1'b0;
    RZout              = 1'b0;
    RegisterAImmediate = 32'd0;
    AddImmediate       = 32'd0;
    busy               = (state_q != IDLE);
    done               = (state_q == DONE);
    case (state_q)
      T0: begin
        RAin               = 1'b1;
        RegisterAImmediate = imm_q;
      end
      T1: begin
        RAout        = 1'b1;
        RZin         = 1'b1;
        AddImmediate = imm_q;
      end
      T2: begin
        RZout = 1'b1;
        RBin  = 1'b1;
      end
      TMOV: begin
        RBout = 1'b1;
        RAin  = 1'b1;
      end
      default: begin
        RAin = 1'b0;
      end
    endcase
  end

  assign op_count = op_count_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for datapath_ctrl with a tiny RA/RB/RZ datapath model driven by the enables.
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        clear;
  logic        start;
  logic [1:0]  op;
  logic [31:0] imm;
  logic        RAin, RBin, RZin, RAout, RBout, RZout;
  logic [31:0] RegisterAImmediate, AddImmediate;
  logic        busy, done;
  logic [7:0]  op_count;

  int checks   = 0;
  int failures = 0;
  int viol     = 0;
  int done_cnt = 0;

  localparam logic [5:0] EN_NONE = 6'b000000; // {RAin,RBin,RZin,RAout,RBout,RZout}
  localparam logic [5:0] EN_T0   = 6'b100000;
  localparam logic [5:0] EN_T1   = 6'b001100;
  localparam logic [5:0] EN_T2   = 6'b010001;
  localparam logic [5:0] EN_TMOV = 6'b100010;

  datapath_ctrl dut (
    .clk(clk), .clear(clear), .start(start), .op(op), .imm(imm),
    .RAin(RAin), .RBin(RBin), .RZin(RZin),
    .RAout(RAout), .RBout(RBout), .RZout(RZout),
    .RegisterAImmediate(RegisterAImmediate), .AddImmediate(AddImmediate),
    .busy(busy), .done(done), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Reference datapath: registers loaded from the shared bus under the controller's enables
  logic [31:0] ra_m = 32'd0, rb_m = 32'd0, rz_m = 32'd0, bus_m;
  always_comb bus_m = RAout ? ra_m : (RBout ? rb_m : (RZout ? rz_m : 32'd0));
  always @(posedge clk) begin
    if (RAin) ra_m <= RBout ? bus_m : RegisterAImmediate;
    if (RZin) rz_m <= bus_m + AddImmediate;
    if (RBin) rb_m <= bus_m;
  end

  always @(negedge clk) begin
    if ($countones({RAout, RBout, RZout}) > 1) viol++;
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [5:0] en, input logic [31:0] rai,
                           input logic [31:0] addi, input logic busy_e, input logic done_e);
    chk({tag, ".en"},   {26'd0, RAin, RBin, RZin, RAout, RBout, RZout}, {26'd0, en});
    chk({tag, ".rai"},  RegisterAImmediate, rai);
    chk({tag, ".addi"}, AddImmediate, addi);
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, busy_e});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, done_e});
  endtask

  initial begin
    int d0;
    int n;
    int gap;
    int cyc;
    clear = 1'b1; start = 1'b0; op = 2'b00; imm = 32'd0;
    repeat (2) @(negedge clk);
    chk_state("rst", EN_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("rst.cnt", {24'd0, op_count}, 32'd0);
    clear = 1'b0;
    @(negedge clk);

    // LDA 5; imm changed while busy must not matter
    start = 1'b1; op = 2'b00; imm = 32'h5;
    @(negedge clk); chk_state("lda.t0", EN_T0, 32'h5, 32'd0, 1'b1, 1'b0);
    start = 1'b0; imm = 32'hDEAD;
    @(negedge clk); chk_state("lda.done", EN_NONE, 32'd0, 32'd0, 1'b1, 1'b1);
    @(negedge clk); chk_state("lda.idle", EN_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("lda.cnt", {24'd0, op_count}, 32'd1);
    chk("lda.ra", ra_m, 32'h5);

    // ADDI 5 with a stray LDA request pulsed during T1
    start = 1'b1; op = 2'b01; imm = 32'h5;
    @(negedge clk); chk_state("addi.t1", EN_T1, 32'd0, 32'h5, 1'b1, 1'b0);
    start = 1'b1; op = 2'b00; imm = 32'h99;
    @(negedge clk); chk_state("addi.t2", EN_T2, 32'd0, 32'd0, 1'b1, 1'b0);
    start = 1'b0;
    @(negedge clk); chk_state("addi.done", EN_NONE, 32'd0, 32'd0, 1'b1, 1'b1);
    @(negedge clk); chk_state("addi.idle", EN_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("addi.cnt", {24'd0, op_count}, 32'd2);
    chk("addi.rb", rb_m, 32'hA);
    chk("addi.dones", done_cnt, 2);

    // MOVBA: RA <- RB
    start = 1'b1; op = 2'b11; imm = 32'h0;
    @(negedge clk); chk_state("mov.tmov", EN_TMOV, 32'd0, 32'd0, 1'b1, 1'b0);
    start = 1'b0;
    @(negedge clk); chk_state("mov.done", EN_NONE, 32'd0, 32'd0, 1'b1, 1'b1);
    @(negedge clk);
    chk("mov.ra", ra_m, 32'hA);
    chk("mov.cnt", {24'd0, op_count}, 32'd3);

    // LDADD 7: RA=7, RZ=RA+7, RB=RZ
    start = 1'b1; op = 2'b10; imm = 32'h7;
    @(negedge clk); chk_state("ldadd.t0", EN_T0, 32'h7, 32'd0, 1'b1, 1'b0);
    start = 1'b0;
    @(negedge clk); chk_state("ldadd.t1", EN_T1, 32'd0, 32'h7, 1'b1, 1'b0);
    @(negedge clk); chk_state("ldadd.t2", EN_T2, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk); chk_state("ldadd.done", EN_NONE, 32'd0, 32'd0, 1'b1, 1'b1);
    @(negedge clk);
    chk("ldadd.rb", rb_m, 32'hE);
    chk("ldadd.cnt", {24'd0, op_count}, 32'd4);

    // Asynchronous clear in the middle of T1 aborts the operation
    start = 1'b1; op = 2'b01; imm = 32'h3;
    @(negedge clk); chk("abort.t1", {31'd0, RAout}, 32'd1);
    start = 1'b0;
    d0 = done_cnt;
    #2 clear = 1'b1;
    #1 chk_state("abort.async", EN_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("abort.cnt0", {24'd0, op_count}, 32'd0);
    repeat (2) @(negedge clk);
    clear = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort.nodone", done_cnt, d0);
    chk("abort.cnt", {24'd0, op_count}, 32'd0);
    chk("abort.idle", {31'd0, busy}, 32'd0);

    // 256 back-to-back LDAs with start held: first start accepted immediately, counter wraps
    start = 1'b1; op = 2'b00; imm = 32'h1;
    @(negedge clk); chk("wrap.first", {31'd0, RAin}, 32'd1);
    n = 0; gap = 5; cyc = 0;
    while (n < 256 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        chk("wrap.cnt", {24'd0, op_count}, n & 255);
        n++;
        gap = 0;
      end else begin
        gap++;
        if (gap == 1) chk("wrap.gap", {31'd0, busy}, 32'd0);
        else if (gap == 2) chk("wrap.t0", {31'd0, RAin}, 32'd1);
      end
    end
    chk("wrap.ops", n, 256);
    start = 1'b0;
    @(negedge clk);
    chk("wrap.cnt_final", {24'd0, op_count}, 32'd0);
    chk("wrap.idle", {31'd0, busy}, 32'd0);
    chk("bus_excl", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
